// File: rtl/mem_responder_if.sv
// CPU-side request/response bus of the memory responder.
// The master (CPU control) drives the strobes; the slave (responder) answers with data and ready.
interface mem_responder_if;
    logic        memread;
    logic        memwrite;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ready;
    logic        err;

    modport master (output memread, memwrite, addr, wdata,
                    input  rdata, ready, err);
    modport slave  (input  memread, memwrite, addr, wdata,
                    output rdata, ready, err);
endinterface

// File: rtl/mem_responder.sv
// Services CPU memread/memwrite requests from a synchronous RAM or an I/O window at IO_BASE and above.
// Optional I/O wait timeout is compiled in with `define MEM_IO_TIMEOUT_EN.
module mem_responder #(
    parameter logic [15:0] IO_BASE        = 16'hFF00,
    parameter int          TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    mem_responder_if.slave cpu,
    output logic        ram_en,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic        io_req,
    output logic        io_we,
    output logic [7:0]  io_addr,
    output logic [15:0] io_wdata,
    input  logic [15:0] io_rdata,
    input  logic        io_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAM_ACC,
        S_RAM_CAP,
        S_IO_WAIT,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_op_wr;
    logic [15:0] r_rdata;
    logic        r_ready;
    logic        r_ram_en;
    logic        r_ram_we;
    logic        r_io_req;
    logic        r_io_we;

`ifdef MEM_IO_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) < 4) ? 4 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    logic          r_err;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // All control outputs are registered and change only on state transitions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_addr   <= 16'h0000;
            r_wdata  <= 16'h0000;
            r_op_wr  <= 1'b0;
            r_rdata  <= 16'h0000;
            r_ready  <= 1'b0;
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
            r_io_req <= 1'b0;
            r_io_we  <= 1'b0;
`ifdef MEM_IO_TIMEOUT_EN
            r_cnt    <= '0;
            r_err    <= 1'b0;
`endif
        end else begin
            r_ready <= 1'b0;
`ifdef MEM_IO_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (cpu.memwrite || cpu.memread) begin
                        r_addr  <= cpu.addr;
                        r_wdata <= cpu.wdata;
                        r_op_wr <= cpu.memwrite;
                        if (cpu.addr >= IO_BASE) begin
                            r_state  <= S_IO_WAIT;
                            r_io_req <= 1'b1;
                            r_io_we  <= cpu.memwrite;
`ifdef MEM_IO_TIMEOUT_EN
                            r_cnt    <= '0;
`endif
                        end else begin
                            r_state  <= S_RAM_ACC;
                            r_ram_en <= 1'b1;
                            r_ram_we <= cpu.memwrite;
                        end
                    end
                end
                S_RAM_ACC: begin
                    r_ram_en <= 1'b0;
                    r_ram_we <= 1'b0;
                    if (r_op_wr) begin
                        r_state <= S_DONE;
                        r_ready <= 1'b1;
                    end else begin
                        r_state <= S_RAM_CAP;
                    end
                end
                S_RAM_CAP: begin
                    r_rdata <= ram_rdata;
                    r_state <= S_DONE;
                    r_ready <= 1'b1;
                end
                S_IO_WAIT: begin
                    // An ack on the same edge as the timeout counts as a normal completion.
                    if (io_ack) begin
                        if (!r_op_wr) begin
                            r_rdata <= io_rdata;
                        end
                        r_io_req <= 1'b0;
                        r_io_we  <= 1'b0;
                        r_state  <= S_DONE;
                        r_ready  <= 1'b1;
                    end
`ifdef MEM_IO_TIMEOUT_EN
                    else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        if (!r_op_wr) begin
                            r_rdata <= 16'hDEAD;
                        end
                        r_io_req <= 1'b0;
                        r_io_we  <= 1'b0;
                        r_state  <= S_DONE;
                        r_ready  <= 1'b1;
                        r_err    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_ram_en <= 1'b0;
                    r_ram_we <= 1'b0;
                    r_io_req <= 1'b0;
                    r_io_we  <= 1'b0;
                end
            endcase
        end
    end

    assign cpu.rdata = r_rdata;
    assign cpu.ready = r_ready;
`ifdef MEM_IO_TIMEOUT_EN
    assign cpu.err   = r_err;
`else
    assign cpu.err   = 1'b0;
`endif

    // RAM passes the full 16-bit address through; I/O sees only the low byte.
    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign io_req    = r_io_req;
    assign io_we     = r_io_we;
    assign io_addr   = r_addr[7:0];
    assign io_wdata  = r_wdata;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder with a small behavioural RAM.
// Each task drives one scenario and checks outputs 1 time unit after the rising edge.
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        io_req;
    logic        io_we;
    logic [7:0]  io_addr;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;
    logic        io_ack;

    int total;
    int bad;

    logic [15:0] ram_mem [0:255];

    mem_responder_if bus ();

    mem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .cpu       (bus),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .io_req    (io_req),
        .io_we     (io_we),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .io_ack    (io_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr[7:0]] <= ram_wdata;
            ram_rdata <= ram_mem[ram_addr[7:0]];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        total++;
        if ({bus.ready, bus.err, ram_en, ram_we, io_req, io_we} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=000000", {bus.ready, bus.err, ram_en, ram_we, io_req, io_we});
        end
        total++;
        if ({bus.rdata, ram_addr, ram_wdata, io_addr, io_wdata} !== 72'h0) begin
            bad++; $display("FAIL reset_data got=%h exp=0", {bus.rdata, ram_addr, ram_wdata, io_addr, io_wdata});
        end
        tick();
        reset = 1'b1;
        tick();
        total++;
        if ({bus.ready, ram_en, io_req} !== 3'b000) begin
            bad++; $display("FAIL reset_idle got=%b exp=000", {bus.ready, ram_en, io_req});
        end
        $display("txn reset released");
    endtask

    task automatic test_ram_write_read;
        bus.memwrite = 1'b1; bus.addr = 16'h0010; bus.wdata = 16'h1234;
        tick();
        bus.memwrite = 1'b0;
        total++;
        if ({ram_en, ram_we, bus.ready} !== 3'b110) begin
            bad++; $display("FAIL ramwr_e0 got=%b exp=110", {ram_en, ram_we, bus.ready});
        end
        total++;
        if ({ram_addr, ram_wdata} !== {16'h0010, 16'h1234}) begin
            bad++; $display("FAIL ramwr_bus got=%h exp=00101234", {ram_addr, ram_wdata});
        end
        tick();
        total++;
        if ({ram_en, ram_we, bus.ready, bus.err} !== 4'b0010) begin
            bad++; $display("FAIL ramwr_ready got=%b exp=0010", {ram_en, ram_we, bus.ready, bus.err});
        end
        tick();
        total++;
        if (bus.ready !== 1'b0) begin
            bad++; $display("FAIL ramwr_pulse got=%b exp=0", bus.ready);
        end
        $display("txn ram write addr=0010 data=1234");

        bus.memread = 1'b1; bus.addr = 16'h0010;
        tick();
        bus.memread = 1'b0;
        total++;
        if ({ram_en, ram_we, bus.ready} !== 3'b100) begin
            bad++; $display("FAIL ramrd_e0 got=%b exp=100", {ram_en, ram_we, bus.ready});
        end
        tick();
        total++;
        if ({ram_en, bus.ready} !== 2'b00) begin
            bad++; $display("FAIL ramrd_cap got=%b exp=00", {ram_en, bus.ready});
        end
        tick();
        total++;
        if ({bus.ready, bus.rdata} !== {1'b1, 16'h1234}) begin
            bad++; $display("FAIL ramrd_data got=%h exp=11234", {bus.ready, bus.rdata});
        end
        tick();
        total++;
        if ({bus.ready, bus.rdata} !== {1'b0, 16'h1234}) begin
            bad++; $display("FAIL ramrd_hold got=%h exp=01234", {bus.ready, bus.rdata});
        end
        $display("txn ram read addr=0010 data=%h", bus.rdata);
    endtask

    task automatic test_io_read;
        bus.memread = 1'b1; bus.addr = 16'hFF05;
        tick();
        bus.memread = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({io_req, io_we, io_addr, bus.ready} !== {1'b1, 1'b0, 8'h05, 1'b0}) begin
                bad++; $display("FAIL ioread_wait%0d got=%b exp=10000001010", k, {io_req, io_we, io_addr, bus.ready});
            end
            if (k == 3) begin
                io_ack = 1'b1; io_rdata = 16'hBEEF;
            end
            tick();
        end
        io_ack = 1'b0; io_rdata = 16'h0000;
        total++;
        if ({bus.ready, bus.err, io_req} !== 3'b100) begin
            bad++; $display("FAIL ioread_ready got=%b exp=100", {bus.ready, bus.err, io_req});
        end
        total++;
        if (bus.rdata !== 16'hBEEF) begin
            bad++; $display("FAIL ioread_data got=%h exp=beef", bus.rdata);
        end
        tick();
        total++;
        if ({bus.ready, bus.rdata} !== {1'b0, 16'hBEEF}) begin
            bad++; $display("FAIL ioread_hold got=%h exp=0beef", {bus.ready, bus.rdata});
        end
        $display("txn io read addr=ff05 data=%h", bus.rdata);
    endtask

    task automatic test_io_write_min;
        io_ack = 1'b1; io_rdata = 16'h2222;
        tick();
        io_ack = 1'b0;
        total++;
        if ({bus.ready, io_req} !== 2'b00) begin
            bad++; $display("FAIL stray_ack got=%b exp=00", {bus.ready, io_req});
        end
        bus.memwrite = 1'b1; bus.addr = 16'hFF01; bus.wdata = 16'h7777;
        tick();
        bus.memwrite = 1'b0;
        total++;
        if ({io_req, io_we, io_addr, io_wdata, ram_en} !== {1'b1, 1'b1, 8'h01, 16'h7777, 1'b0}) begin
            bad++; $display("FAIL iowr_drive got=%h", {io_req, io_we, io_addr, io_wdata, ram_en});
        end
        io_ack = 1'b1; io_rdata = 16'h1111;
        tick();
        io_ack = 1'b0;
        total++;
        if ({bus.ready, io_req, bus.rdata} !== {1'b1, 1'b0, 16'hBEEF}) begin
            bad++; $display("FAIL iowr_min got=%h exp=2beef", {bus.ready, io_req, bus.rdata});
        end
        tick();
        $display("txn io write addr=ff01 data=7777");
    endtask

    task automatic test_write_priority;
        bus.memread = 1'b1; bus.memwrite = 1'b1; bus.addr = 16'h0020; bus.wdata = 16'h00AA;
        tick();
        bus.memread = 1'b0; bus.memwrite = 1'b0;
        total++;
        if ({ram_en, ram_we} !== 2'b11) begin
            bad++; $display("FAIL prio_we got=%b exp=11", {ram_en, ram_we});
        end
        tick();
        total++;
        if ({bus.ready, bus.rdata} !== {1'b1, 16'hBEEF}) begin
            bad++; $display("FAIL prio_rdata got=%h exp=1beef", {bus.ready, bus.rdata});
        end
        tick();
        bus.memread = 1'b1; bus.addr = 16'h0020;
        tick();
        bus.memread = 1'b0;
        tick();
        tick();
        total++;
        if ({bus.ready, bus.rdata} !== {1'b1, 16'h00AA}) begin
            bad++; $display("FAIL prio_readback got=%h exp=100aa", {bus.ready, bus.rdata});
        end
        tick();
        $display("txn priority write addr=0020 readback=%h", bus.rdata);
    endtask

    task automatic test_back_to_back;
        bus.memwrite = 1'b1; bus.addr = 16'h0030; bus.wdata = 16'h0C0C;
        tick();
        bus.memwrite = 1'b0;
        tick();
        bus.memread = 1'b1;
        tick();
        total++;
        if ({ram_en, bus.ready} !== 2'b00) begin
            bad++; $display("FAIL b2b_idle got=%b exp=00", {ram_en, bus.ready});
        end
        tick();
        bus.memread = 1'b0;
        total++;
        if ({ram_en, ram_we} !== 2'b10) begin
            bad++; $display("FAIL b2b_start got=%b exp=10", {ram_en, ram_we});
        end
        tick();
        tick();
        total++;
        if ({bus.ready, bus.rdata} !== {1'b1, 16'h0C0C}) begin
            bad++; $display("FAIL b2b_data got=%h exp=10c0c", {bus.ready, bus.rdata});
        end
        tick();
        $display("txn back-to-back write/read addr=0030 data=%h", bus.rdata);
    endtask

    task automatic test_reset_midread;
        bus.memread = 1'b1; bus.addr = 16'h0010;
        tick();
        bus.memread = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        total++;
        if ({bus.ready, bus.err, ram_en, ram_we, io_req, io_we} !== 6'b0) begin
            bad++; $display("FAIL midrst_ctrl got=%b exp=000000", {bus.ready, bus.err, ram_en, ram_we, io_req, io_we});
        end
        total++;
        if ({bus.rdata, ram_addr} !== 32'h0) begin
            bad++; $display("FAIL midrst_data got=%h exp=0", {bus.rdata, ram_addr});
        end
        tick();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({bus.ready, ram_en, bus.rdata} !== 18'h0) begin
            bad++; $display("FAIL midrst_after got=%h exp=0", {bus.ready, ram_en, bus.rdata});
        end
        bus.memread = 1'b1; bus.addr = 16'h0010;
        tick();
        bus.memread = 1'b0;
        tick();
        tick();
        total++;
        if ({bus.ready, bus.rdata} !== {1'b1, 16'h1234}) begin
            bad++; $display("FAIL midrst_recover got=%h exp=11234", {bus.ready, bus.rdata});
        end
        tick();
        $display("txn reset mid-read, recovered data=%h", bus.rdata);
    endtask

    task automatic test_timeout;
        bus.memread = 1'b1; bus.addr = 16'hFF10;
        tick();
        bus.memread = 1'b0;
`ifdef MEM_IO_TIMEOUT_EN
        for (int k = 1; k < 15; k++) begin
            tick();
            total++;
            if ({io_req, bus.ready} !== 2'b10) begin
                bad++; $display("FAIL tmo_wait%0d got=%b exp=10", k, {io_req, bus.ready});
            end
        end
        tick();
        total++;
        if ({bus.ready, bus.err, io_req, bus.rdata} !== {3'b110, 16'hDEAD}) begin
            bad++; $display("FAIL tmo_fire got=%h exp=6dead", {bus.ready, bus.err, io_req, bus.rdata});
        end
        tick();
        total++;
        if ({bus.ready, bus.err} !== 2'b00) begin
            bad++; $display("FAIL tmo_pulse got=%b exp=00", {bus.ready, bus.err});
        end
        $display("txn io read timeout addr=ff10 data=%h", bus.rdata);
`else
        for (int k = 0; k < 100; k++) begin
            tick();
            total++;
            if ({io_req, bus.ready, bus.err} !== 3'b100) begin
                bad++; $display("FAIL notmo_wait%0d got=%b exp=100", k, {io_req, bus.ready, bus.err});
            end
        end
        io_ack = 1'b1; io_rdata = 16'h5A5A;
        tick();
        io_ack = 1'b0;
        total++;
        if ({bus.ready, bus.err, bus.rdata} !== {2'b10, 16'h5A5A}) begin
            bad++; $display("FAIL notmo_ack got=%h exp=25a5a", {bus.ready, bus.err, bus.rdata});
        end
        tick();
        $display("txn io read held 100 cycles then acked data=%h", bus.rdata);
`endif
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        bus.memread = 1'b0;
        bus.memwrite = 1'b0;
        bus.addr = 16'h0000;
        bus.wdata = 16'h0000;
        io_rdata = 16'h0000;
        io_ack = 1'b0;
        test_reset();
        test_ram_write_read();
        test_io_read();
        test_io_write_min();
        test_write_priority();
        test_back_to_back();
        test_reset_midread();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
